// File: rtl/wb_cmd_pkg.sv
// Shared constants and state encoding for the byte-stream Wishbone command master.
package wb_cmd_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;

    localparam logic [7:0] ST_ACK    = 8'h00;
    localparam logic [7:0] ST_ERR    = 8'h01;
    localparam logic [7:0] ST_TMO    = 8'h02;
    localparam logic [7:0] ST_BADOP  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_STATUS,
        S_RDATA
    } state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Byte-framed command decoder driving single classic Wishbone cycles and
// streaming back a status byte plus, for successful reads, four data bytes.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_busy
);
    import wb_cmd_pkg::*;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q,  state_d;
    logic [1:0]       cnt_q,    cnt_d;
    logic [31:0]      adr_q,    adr_d;
    logic [31:0]      dat_q,    dat_d;
    logic             we_q,     we_d;
    logic [7:0]       status_q, status_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;

    logic rx_fire;
    logic tx_fire;

    assign o_rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign o_tx_valid = (state_q == S_STATUS) || (state_q == S_RDATA);
    assign o_wb_cyc   = (state_q == S_BUS);
    assign o_wb_stb   = o_wb_cyc;
    assign o_wb_we    = o_wb_cyc && we_q;
    assign o_wb_sel   = o_wb_cyc ? 4'hF : 4'h0;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_busy     = (state_q != S_IDLE);

    assign rx_fire = i_rx_valid && o_rx_ready;
    assign tx_fire = o_tx_valid && i_tx_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        status_d  = status_q;
        tmo_d     = tmo_q;
        o_tx_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
                        we_d    = (i_rx_data == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        we_d     = 1'b0;
                        status_d = ST_BADOP;
                        state_d  = S_STATUS;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = we_q ? S_WDATA : S_BUS;
                        tmo_d   = '0;
                    end
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    dat_d = {dat_q[23:0], i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        tmo_d   = '0;
                    end
                end
            end
            S_BUS: begin
                // err outranks ack, and both outrank a timeout reached the same cycle.
                if (i_wb_err) begin
                    status_d = ST_ERR;
                    state_d  = S_STATUS;
                end else if (i_wb_ack) begin
                    status_d = ST_ACK;
                    if (!we_q) dat_d = i_wb_dat;
                    state_d  = S_STATUS;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TMO;
                    state_d  = S_STATUS;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_STATUS: begin
                o_tx_data = status_q;
                if (tx_fire) begin
                    cnt_d   = 2'd0;
                    state_d = (status_q == ST_ACK && !we_q) ? S_RDATA : S_IDLE;
                end
            end
            S_RDATA: begin
                o_tx_data = dat_q[31:24];
                if (tx_fire) begin
                    dat_d = {dat_q[23:0], 8'h00};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            we_q     <= 1'b0;
            status_q <= 8'h00;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench: randomized command frames, a reactive Wishbone slave and
// response sink, checked against a frame-level model of the expected bus cycle and reply.
module tb_wb_cmd_master;

    localparam int TMO    = 8;
    localparam int BUDGET = 300;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    localparam logic [81:0] RST_OUTS = {6'b000001, 4'h0, 32'h0, 32'h0, 8'h00};

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_dat = 32'h0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_dat   (i_wb_dat),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_busy     (o_busy)
    );

    function automatic logic [81:0] outs();
        return {o_wb_cyc, o_wb_stb, o_wb_we, o_tx_valid, o_busy, o_rx_ready,
                o_wb_sel, o_wb_adr, o_wb_dat, o_tx_data};
    endfunction

    task automatic quiet_inputs();
        i_rx_valid = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_err   = 1'b0;
        i_tx_ready = 1'b0;
    endtask

    // Drives one full command, plays slave and response sink, and compares
    // the bus cycle and reply against what the frame rules predict.
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int mode, input int ack_at,
                           input int hold, input string tag);
        logic [7:0] frame[$];
        logic [7:0] exp_rsp[$];
        logic [7:0] got[$];
        logic [7:0] prev_data;
        bit   is_wr, is_rd, is_bus, timed_out, done;
        bit   prev_cyc, prev_valid, prev_ready;
        int   idx, t, last_acc, last_cyc, first_tx, cyc_len, episodes, stall, want_stall;
        int   exp_t, exp_len;

        is_wr  = (op == 8'h57);
        is_rd  = (op == 8'h52);
        is_bus = is_wr || is_rd;
        timed_out = (mode == M_NONE) || (ack_at > TMO);

        frame.push_back(op);
        if (is_bus) for (int i = 3; i >= 0; i--) frame.push_back(adr[8*i +: 8]);
        if (is_wr)  for (int i = 3; i >= 0; i--) frame.push_back(wdat[8*i +: 8]);

        if (!is_bus)                              exp_rsp.push_back(8'hFF);
        else if (timed_out)                       exp_rsp.push_back(8'h02);
        else if (mode == M_ERR || mode == M_BOTH) exp_rsp.push_back(8'h01);
        else begin
            exp_rsp.push_back(8'h00);
            if (is_rd) for (int i = 3; i >= 0; i--) exp_rsp.push_back(rdat[8*i +: 8]);
        end
        exp_len = !is_bus ? 0 : (timed_out ? TMO : ack_at);

        idx = 0; t = 0; last_acc = -1; last_cyc = -1; first_tx = -1;
        cyc_len = 0; episodes = 0; stall = 0; done = 0;
        prev_cyc = 0; prev_valid = 0; prev_ready = 0; prev_data = 8'h00;
        want_stall = (hold < 0) ? int'($urandom_range(0, 3)) : hold;

        while (!done && t <= BUDGET) begin
            @(negedge i_clk);
            t++;
            if (idx == frame.size() && got.size() == exp_rsp.size()) begin
                quiet_inputs();
                checks++;
                if (o_busy !== 1'b0 || o_tx_valid !== 1'b0)
                    $display("FAIL %s idle_after: busy=%b tx_valid=%b expected 0/0", tag, o_busy, o_tx_valid);
                done = 1;
            end else begin
                if (idx < frame.size()) begin
                    i_rx_valid = 1'b1;
                    i_rx_data  = frame[idx];
                end else begin
                    i_rx_valid = 1'b0;
                    i_rx_data  = 8'($urandom);
                end
                if (i_rx_valid && o_rx_ready) begin
                    idx++;
                    last_acc = t;
                end

                checks++;
                if (o_wb_stb !== o_wb_cyc) begin
                    errors++;
                    $display("FAIL %s stb_eq_cyc: stb=%b cyc=%b", tag, o_wb_stb, o_wb_cyc);
                end
                checks++;
                if ((o_wb_cyc || o_tx_valid) && o_rx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s rx_ready_busy: rx_ready=%b expected 0", tag, o_rx_ready);
                end

                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
                i_wb_dat = $urandom;
                if (o_wb_cyc) begin
                    if (!prev_cyc) begin
                        episodes++;
                        checks++;
                        if (t != last_acc + 1) begin
                            errors++;
                            $display("FAIL %s cyc_latency: cyc at %0d expected %0d", tag, t, last_acc + 1);
                        end
                    end
                    cyc_len++;
                    last_cyc = t;
                    checks++;
                    if (o_wb_adr !== adr || o_wb_we !== is_wr || o_wb_sel !== 4'hF ||
                        (is_wr && o_wb_dat !== wdat)) begin
                        errors++;
                        $display("FAIL %s bus_fields: adr=%h we=%b sel=%h dat=%h expected adr=%h we=%b sel=f dat=%h",
                                 tag, o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat, adr, is_wr, wdat);
                    end
                    if (cyc_len == ack_at) begin
                        case (mode)
                            M_ACK:  begin i_wb_ack = 1'b1; i_wb_dat = rdat; end
                            M_ERR:  i_wb_err = 1'b1;
                            M_BOTH: begin i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_dat = rdat; end
                            default: ;
                        endcase
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    // stray responses outside a bus cycle must be ignored
                    i_wb_ack = 1'($urandom);
                    i_wb_err = 1'($urandom);
                end

                if (o_tx_valid) begin
                    if (first_tx < 0) begin
                        first_tx = t;
                        exp_t = is_bus ? last_cyc + 1 : last_acc + 1;
                        checks++;
                        if (t != exp_t || o_wb_cyc !== 1'b0) begin
                            errors++;
                            $display("FAIL %s status_latency: tx_valid at %0d cyc=%b expected %0d cyc=0",
                                     tag, t, o_wb_cyc, exp_t);
                        end
                    end
                    if (prev_valid && !prev_ready) begin
                        checks++;
                        if (o_tx_data !== prev_data) begin
                            errors++;
                            $display("FAIL %s tx_stable: data=%h expected %h", tag, o_tx_data, prev_data);
                        end
                    end
                    if (stall < want_stall) begin
                        i_tx_ready = 1'b0;
                        stall++;
                    end else begin
                        i_tx_ready = 1'b1;
                        got.push_back(o_tx_data);
                        stall = 0;
                        want_stall = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
                    end
                end else begin
                    i_tx_ready = 1'($urandom);
                end
                prev_cyc   = o_wb_cyc;
                prev_valid = o_tx_valid;
                prev_ready = i_tx_ready;
                prev_data  = o_tx_data;
            end
        end
        quiet_inputs();

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s budget: no completion in %0d cycles (bytes in %0d/%0d, rsp %0d/%0d)",
                     tag, BUDGET, idx, frame.size(), got.size(), exp_rsp.size());
        end
        checks++;
        if (episodes != (is_bus ? 1 : 0) || cyc_len != exp_len) begin
            errors++;
            $display("FAIL %s bus_cycles: episodes=%0d len=%0d expected %0d/%0d",
                     tag, episodes, cyc_len, is_bus ? 1 : 0, exp_len);
        end
        checks++;
        if (got.size() != exp_rsp.size()) begin
            errors++;
            $display("FAIL %s rsp_len: got %0d bytes expected %0d", tag, got.size(), exp_rsp.size());
        end
        for (int i = 0; i < exp_rsp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_rsp[i]) begin
                errors++;
                $display("FAIL %s rsp[%0d]: got %h expected %h", tag, i, got[i], exp_rsp[i]);
            end
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_values: outs=%h expected %h", outs(), RST_OUTS);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_write();
        run_cmd(8'h57, 32'h3000_1000, 32'hDEAD_BEEF, 32'h0, M_ACK, 4, 0, "write");
    endtask

    task automatic test_read();
        run_cmd(8'h52, 32'h3000_1000, 32'h0, 32'h1234_5678, M_ACK, 2, 5, "read_stall");
    endtask

    task automatic test_error_timeout();
        run_cmd(8'h52, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, M_ERR,  3,   0, "read_err");
        run_cmd(8'h52, 32'h0000_0044, 32'h0, 32'h0,         M_NONE, 0,   0, "read_timeout");
        run_cmd(8'h57, 32'h0000_0048, 32'h0102_0304, 32'h0, M_NONE, 0,   1, "write_timeout");
        run_cmd(8'h52, 32'h0000_004C, 32'h0, 32'hAAAA_5555, M_BOTH, 1,   0, "ack_err_same");
        run_cmd(8'h52, 32'h0000_0050, 32'h0, 32'h8765_4321, M_ACK,  TMO, 0, "ack_at_limit");
        run_cmd(8'h57, 32'h0000_0054, 32'hFFFF_0000, 32'h0, M_ERR,  TMO, 0, "err_at_limit");
        run_cmd(8'h52, 32'h0000_0058, 32'h0, 32'h0BAD_CAFE, M_ACK,  1,   0, "min_latency");
    endtask

    task automatic test_bad_opcode();
        run_cmd(8'h41, 32'h0, 32'h0, 32'h0, M_ACK, 1, 2, "bad_opcode");
        run_cmd(8'h52, 32'h2000_0000, 32'h0, 32'h5A5A_A5A5, M_ACK, 2, 0, "after_bad");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] part[3];
        part = '{8'h52, 8'h30, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_rx_valid = 1'b1;
            i_rx_data  = part[i];
        end
        @(negedge i_clk);
        quiet_inputs();
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL rst_mid_frame: outs=%h expected %h", outs(), RST_OUTS);
        end
        i_reset_n  = 1'b1;
        i_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_frame_quiet: tx_valid=%b busy=%b expected 0/0", o_tx_valid, o_busy);
            end
        end
        i_tx_ready = 1'b0;
        run_cmd(8'h57, 32'h1000_0004, 32'h1357_9BDF, 32'h0, M_ACK, 2, 0, "after_rst_frame");
    endtask

    task automatic test_reset_mid_bus();
        logic [7:0] part[5];
        bit seen;
        part = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_rx_valid = 1'b1;
            i_rx_data  = part[i];
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge i_clk);
            i_rx_valid = 1'b0;
            seen = o_wb_cyc;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_bus_cyc: cyc never rose, cyc=%b expected 1", o_wb_cyc);
        end
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL rst_mid_bus: outs=%h expected %h", outs(), RST_OUTS);
        end
        i_reset_n  = 1'b1;
        i_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_tx_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_bus_quiet: tx_valid=%b cyc=%b expected 0/0", o_tx_valid, o_wb_cyc);
            end
        end
        i_tx_ready = 1'b0;
        run_cmd(8'h52, 32'h4000_0010, 32'h0, 32'h2468_ACE0, M_ACK, 3, 1, "after_rst_bus");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  op;
        logic [31:0] adr, wdat, rdat;
        int mode, r, m;
        for (int n = 0; n < 25; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
            end else begin
                op = (r < 5) ? 8'h52 : 8'h57;
            end
            m = int'($urandom_range(0, 9));
            mode = (m < 6) ? M_ACK : (m == 6) ? M_ERR : (m == 7) ? M_BOTH : M_NONE;
            adr  = $urandom;
            wdat = $urandom;
            rdat = $urandom;
            run_cmd(op, adr, wdat, rdat, mode, int'($urandom_range(1, TMO)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error_timeout();
        test_bad_opcode();
        test_reset_mid_frame();
        test_reset_mid_bus();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
